// File: rtl/rc_pwm_generator.sv
// RC servo pulse-train generator: one programmable-width high pulse at the start
// of every fixed-length frame, with width changes applied only at frame boundaries.
module rc_pwm_generator #(
  parameter int FRAME_PERIOD  = 20000,
  parameter int MIN_PULSE     = 1000,
  parameter int MAX_PULSE     = 2000,
  parameter int NEUTRAL_PULSE = 1500,
  parameter int COUNTER_WIDTH = 15
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     load_i,
  input  logic [COUNTER_WIDTH-1:0] width_i,
  output logic                     output_pin_o,
  output logic                     frame_start_o,
  output logic                     clamped_o
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [COUNTER_WIDTH-1:0] LP_LAST    = COUNTER_WIDTH'(FRAME_PERIOD - 1);
  localparam logic [COUNTER_WIDTH-1:0] LP_MIN     = COUNTER_WIDTH'(MIN_PULSE);
  localparam logic [COUNTER_WIDTH-1:0] LP_MAX     = COUNTER_WIDTH'(MAX_PULSE);
  localparam logic [COUNTER_WIDTH-1:0] LP_NEUTRAL = COUNTER_WIDTH'(NEUTRAL_PULSE);
  localparam logic [COUNTER_WIDTH-1:0] LP_ONE     = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [COUNTER_WIDTH-1:0] clamp_width(input logic [COUNTER_WIDTH-1:0] w);
    if (w < LP_MIN)      return LP_MIN;
    else if (w > LP_MAX) return LP_MAX;
    else                 return w;
  endfunction

  function automatic logic out_of_range(input logic [COUNTER_WIDTH-1:0] w);
    return (w < LP_MIN) || (w > LP_MAX);
  endfunction

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic [COUNTER_WIDTH-1:0] r_pending_width;
  logic [COUNTER_WIDTH-1:0] r_active_width;
  logic                     r_pin;
  logic                     r_frame_start;
  logic                     r_clamped;

  state_t                   w_next_state;
  logic [COUNTER_WIDTH-1:0] w_next_counter;
  logic                     w_next_pin;
  logic                     w_start;
  logic [COUNTER_WIDTH-1:0] w_load_width;

  assign w_load_width = clamp_width(width_i);

  always_comb begin
    w_next_state   = r_state;
    w_next_counter = r_counter;
    w_next_pin     = 1'b0;
    w_start        = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_counter = '0;
        w_start        = enable_i;
      end
      PULSE: begin
        w_next_counter = r_counter + LP_ONE;
        w_next_pin     = 1'b1;
        if (r_counter == (r_active_width - LP_ONE)) begin
          w_next_state = GAP;
          w_next_pin   = 1'b0;
        end
      end
      GAP: begin
        // enable_i only matters on the final cycle, so frames are never cut short
        if (r_counter == LP_LAST) begin
          w_next_counter = '0;
          if (enable_i) w_start = 1'b1;
          else          w_next_state = IDLE;
        end else begin
          w_next_counter = r_counter + LP_ONE;
        end
      end
      default: begin
        w_next_state   = IDLE;
        w_next_counter = '0;
      end
    endcase
    if (w_start) begin
      w_next_state   = PULSE;
      w_next_counter = '0;
      w_next_pin     = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state         <= IDLE;
      r_counter       <= '0;
      r_pin           <= 1'b0;
      r_frame_start   <= 1'b0;
      r_clamped       <= 1'b0;
      r_pending_width <= LP_NEUTRAL;
      r_active_width  <= LP_NEUTRAL;
    end else begin
      r_state       <= w_next_state;
      r_counter     <= w_next_counter;
      r_pin         <= w_next_pin;
      r_frame_start <= w_start;
      if (load_i) begin
        r_pending_width <= w_load_width;
        r_clamped       <= out_of_range(width_i);
      end
      // a load landing on the start edge bypasses pending and hits this frame
      if (w_start) r_active_width <= load_i ? w_load_width : r_pending_width;
    end
  end

  assign output_pin_o  = r_pin;
  assign frame_start_o = r_frame_start;
  assign clamped_o     = r_clamped;

endmodule

// File: tb/tb_rc_pwm_generator.sv
// Scoreboard bench for rc_pwm_generator on a scaled-down frame (200 cycles, 10..20 pulse).
module tb_rc_pwm_generator;
  localparam int FP   = 200;
  localparam int MINP = 10;
  localparam int MAXP = 20;
  localparam int NEUT = 15;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          load_i = 1'b0;
  logic [CW-1:0] width_i = '0;
  logic          pin, fs, clamped;

  always #5 clk = ~clk;

  rc_pwm_generator #(
    .FRAME_PERIOD(FP), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
    .NEUTRAL_PULSE(NEUT), .COUNTER_WIDTH(CW)
  ) dut (
    .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i), .load_i(load_i),
    .width_i(width_i), .output_pin_o(pin), .frame_start_o(fs), .clamped_o(clamped)
  );

  typedef struct { int w; int per; } frame_t;
  frame_t sb[$];
  int     clamp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // expected pulse width of the next frame, and its distance from the previous start (0 = unchecked)
  task automatic expect_frame(input int w, input int per);
    frame_t e;
    e.w = w;
    e.per = per;
    sb.push_back(e);
  endtask

  task automatic drive_load(input int w, input int exp_clamped);
    load_i  = 1'b1;
    width_i = CW'(w);
    clamp_q.push_back(exp_clamped);
  endtask

  task automatic do_load(input int w, input int exp_clamped);
    drive_load(w, exp_clamped);
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 2*FP + 10);
    if (!fs) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame start timeout: got none in %0d cycles, expected one", n);
    end
  endtask

  // monitor
  int     cyc = 0;
  int     last_fs = 0;
  int     hcnt = 0;
  int     exp_w = 0;
  bit     have_exp = 1'b0;
  bit     prev_pin = 1'b0;
  frame_t cur;
  int     exp_c;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset_i) begin
      check("reset pin", int'(pin), 0);
      check("reset frame_start", int'(fs), 0);
      check("reset clamped", int'(clamped), 0);
      have_exp = 1'b0;
      hcnt = 0;
    end else begin
      if (load_i) begin
        if (clamp_q.size() == 0) flag("unexpected load");
        else begin
          exp_c = clamp_q.pop_front();
          check("clamped", int'(clamped), exp_c);
        end
      end
      if (fs) begin
        if (sb.size() == 0) flag("unexpected frame start");
        else begin
          cur = sb.pop_front();
          if (cur.per != 0) check("frame period", cyc - last_fs, cur.per);
          exp_w = cur.w;
          have_exp = 1'b1;
        end
        check("pin rises with frame start", int'({prev_pin, pin}), 1);
        last_fs = cyc;
        hcnt = 0;
      end else if (pin && !prev_pin) begin
        flag("pin rise without frame start");
      end
      if (pin) hcnt++;
      if (prev_pin && !pin) begin
        if (have_exp) check("pulse width", hcnt, exp_w);
        else flag("unexpected pulse");
        have_exp = 1'b0;
      end
    end
    prev_pin = pin;
  end

  initial begin
    idle(20);
    reset_i = 1'b0;
    idle(5);

    // neutral width after reset, steady frames
    expect_frame(15, 0);
    enable_i = 1'b1;
    wait_fs();
    expect_frame(15, 200);
    wait_fs();

    // mid-frame loads take effect next frame
    idle(50);
    do_load(19, 0);
    expect_frame(19, 200);
    wait_fs();
    idle(30);
    do_load(10, 0);
    expect_frame(10, 200);
    wait_fs();

    // clamping
    idle(5);
    do_load(5, 1);
    expect_frame(10, 200);
    wait_fs();
    do_load(30, 1);
    expect_frame(20, 200);
    wait_fs();
    do_load(14, 0);
    expect_frame(14, 200);
    wait_fs();

    // load on the start edge goes straight into that frame
    expect_frame(12, 200);
    idle(FP - 1);
    do_load(12, 0);
    idle(10);
    drive_load(11, 0);
    @(negedge clk);
    drive_load(18, 0);
    @(negedge clk);
    load_i = 1'b0;
    expect_frame(18, 200);
    wait_fs();

    // disable mid-pulse: frame completes, then silence
    idle(5);
    enable_i = 1'b0;
    idle(2*FP);

    // restart, then a brief drop that must not disturb the frame
    expect_frame(18, 0);
    enable_i = 1'b1;
    wait_fs();
    idle(5);
    enable_i = 1'b0;
    idle(95);
    enable_i = 1'b1;
    expect_frame(18, 200);
    wait_fs();

    // reset mid-pulse, no frame while disabled, neutral width afterwards
    idle(5);
    reset_i = 1'b1;
    enable_i = 1'b0;
    idle(3);
    reset_i = 1'b0;
    idle(50);
    expect_frame(15, 0);
    enable_i = 1'b1;
    wait_fs();
    idle(3);
    enable_i = 1'b0;
    idle(FP + 50);

    check("frames left in scoreboard", sb.size(), 0);
    check("loads left in scoreboard", clamp_q.size(), 0);
    check("unfinished pulse", int'(have_exp), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rc_pwm_generator.md
# rc_pwm_generator

Generates the standard RC servo/receiver pulse train: one high pulse of programmable width at the start of every fixed-length frame (defaults 1000–2000 cycles high in a 20000-cycle frame, i.e. 1–2 ms in 20 ms at a 1 MHz clock). It is the transmit-side counterpart of the PWM analyzer and drives the same kind of signal that the analyzer's `enable_i` samples. A width command is captured through a load strobe and applied only at a frame boundary, so every pulse on the pin is complete and glitch-free.

## Interface
- `FRAME_PERIOD`, 20000: frame length in clock cycles.
- `MIN_PULSE`, 1000: minimum pulse width in cycles; lower commands are clamped up to it.
- `MAX_PULSE`, 2000: maximum pulse width in cycles; higher commands are clamped down to it.
- `NEUTRAL_PULSE`, 1500: pulse width in effect after reset.
- `COUNTER_WIDTH`, 15: width of the frame counter and of the width command; must hold `FRAME_PERIOD-1`.

Ports:
- `clock_i`  in  1  clock; all logic on the rising edge.
- `reset_i`  in  1  reset, synchronous, active-high.
- `enable_i`  in  1  run request; high = generate frames.
- `load_i`  in  1  single-cycle strobe; captures `width_i`.
- `width_i`  in  COUNTER_WIDTH  requested pulse width in cycles, unsigned.
- `output_pin_o`  out  1  PWM output, registered.
- `frame_start_o`  out  1  one-cycle pulse, high in the first cycle of each frame.
- `clamped_o`  out  1  registered; 1 if the most recent load was clamped.

## Operation
- Registers: `state` {IDLE, PULSE, GAP}, `counter`, `pending_width`, `active_width`, `clamped_o`.
- Load: on `load_i`=1, `pending_width` <= clamp(`width_i`) to [MIN_PULSE, MAX_PULSE]. `clamped_o` <= (`width_i` < MIN_PULSE or `width_i` > MAX_PULSE). Loads are accepted in every state. Back-to-back loads: the last one wins.
- Frame start event: applies at the first cycle of a frame, entered from IDLE with `enable_i`=1, or from GAP at `counter`==FRAME_PERIOD-1 with `enable_i`=1.
  - Next cycle: `counter`=0, `state`=PULSE, `output_pin_o`=1, `frame_start_o`=1.
  - `active_width` <= `load_i` ? clamp(`width_i`) : `pending_width`. A load coinciding with the start event takes effect in the new frame.
- PULSE: `output_pin_o`=1 and `counter` increments each cycle. When `counter`==`active_width`-1, the next state is GAP with the output low.
- GAP: output low and `counter` increments. At `counter`==FRAME_PERIOD-1:
  - `enable_i`=1: frame start.
  - `enable_i`=0: IDLE, with `counter` cleared.
- IDLE: output low and `counter` held at 0.
- `enable_i` is sampled only in IDLE and at the last GAP cycle:
  - Deasserting mid-frame never truncates a pulse or a frame.
  - Re-asserting before the frame ends continues seamlessly.
- `active_width` is never changed mid-frame.
- Arithmetic: unsigned compares and saturation only; the counter never wraps past FRAME_PERIOD-1.
- Reset (any state, including mid-pulse), effective the next edge:
  - `state`=IDLE, `counter`=0.
  - `output_pin_o`=0, `frame_start_o`=0, `clamped_o`=0.
  - `pending_width`=`active_width`=NEUTRAL_PULSE.
- `reset_i` overrides `load_i` and `enable_i`.

## Timing
- Start latency: `enable_i` high at IDLE edge N gives `output_pin_o`=1 and `frame_start_o`=1 after edge N+1.
- Pulse: exactly `active_width` consecutive high cycles.
- Frame: exactly FRAME_PERIOD cycles from rising edge to rising edge while enabled.
- Load to pin: the value appears in the next frame that starts at least one cycle after the load, or in the frame whose start coincides with the load.
- `clamped_o` updates one cycle after `load_i`.
- Stop: after `enable_i` falls, the pin stays low once the current frame's last cycle has passed.

## Test plan
- Reset 200 cycles, enable with no load: pin high 1500 cycles, low 18500, repeating. `frame_start_o` fires every 20000 cycles.
- Load 1950 mid-frame: current frame keeps its old width, next frame is high 1950. Load 1000: next frame high 1000. `clamped_o`=0 both times.
- Load 500 gives high 1000 and `clamped_o`=1. Load 3000 gives high 2000 and `clamped_o`=1. Load 1400 gives `clamped_o`=0.
- Load coincident with the frame start cycle, value 1200: that frame is high 1200. Two consecutive loads 1100 then 1800: next frame is high 1800.
- Drop `enable_i` 500 cycles into a 1500-cycle pulse: pulse completes at 1500, frame completes at 20000, then the pin stays low. Re-enable at cycle 10000 of a frame: no restart, the next pulse begins at cycle 20000.
- Assert `reset_i` mid-pulse: pin low next cycle, width back to 1500, no frame until `reset_i`=0 and `enable_i`=1.
